// File: rtl/sprite_pkg.sv
// Shared sprite constants: sprite geometry, ROM depth and palette index type.
package sprite_pkg;
    localparam int SPRITE_DIM       = 14;
    localparam int SPRITE_ROM_DEPTH = SPRITE_DIM * SPRITE_DIM;
    localparam int PAL_IDX_W        = 2;

    typedef logic [PAL_IDX_W-1:0] pal_idx_t;

    localparam pal_idx_t PAL_TRANSPARENT = '0;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Renderer-side request/return bus plus the ROM address/data pair of the arbiter.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = sprite_pkg::PAL_IDX_W
);
    import sprite_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_oob;

    modport master (
        output req, addr, rom_q,
        input  gnt, rom_address, rd_valid, rd_data, rd_oob
    );

    modport slave (
        input  req, addr, rom_q,
        output gnt, rom_address, rd_valid, rd_data, rd_oob
    );
endinterface

// File: rtl/sprite_rr_pick.sv
// Round-robin pick: first asserted req at or after ptr, wrapping mod NUM_REQ.
module sprite_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int PTR_W = $clog2(NUM_REQ);

    always_comb begin
        gnt = '0;
        idx = '0;
        // Scan farthest-first so the candidate nearest ptr is the last writer.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM; palette index returns one cycle after grant.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = PAL_IDX_W,
    parameter int ROM_DEPTH = SPRITE_ROM_DEPTH
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d, pick_idx;
    logic [NUM_REQ-1:0] pick_gnt, gnt;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_oob_q, rd_oob_d;
    logic [ADDR_W-1:0]  rom_address;
    logic               grant_any, oob;

    sprite_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        // Grant is combinational, so it must be masked while reset is held.
        gnt         = reset_n ? pick_gnt : '0;
        grant_any   = |gnt;
        rom_address = grant_any ? bus.addr[pick_idx*ADDR_W +: ADDR_W] : '0;
        oob         = int'(rom_address) >= ROM_DEPTH;

        ptr_d = ptr_q;
        if (grant_any)
            ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

        rd_valid_d = gnt;
        rd_data_d  = (grant_any && !oob) ? bus.rom_q : DATA_W'(PAL_TRANSPARENT);
        rd_oob_d   = grant_any && oob;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.rom_address = rom_address;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_oob      = rd_oob_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a negedge-clocked ROM model.
module tb_sprite_rom_arbiter;
    localparam int NR    = 4;
    localparam int AW    = 8;
    localparam int DW    = 2;
    localparam int DEPTH = 196;

    typedef struct packed {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
        logic          o;
    } ret_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    int   last_idx = -1;
    ret_t sb[$];

    sprite_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH)) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        int v;
        v = int'(a) + int'(a >> 1) + 1;
        return DW'(v);
    endfunction

    always @(negedge vga_clk) bus.rom_q <= rom_fn(bus.rom_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input int a);
        bus.addr[i*AW +: AW] = AW'(a);
    endtask

    // One arbitration cycle: check grant mid-cycle, push expected return, check it after the edge.
    task automatic tick(input string tag);
        logic [NR-1:0] eg;
        logic [AW-1:0] ea;
        logic          eo;
        int            k;
        ret_t          r;
        ret_t          got;
        @(negedge vga_clk);
        #1;
        eg = '0;
        k  = -1;
        for (int i = 0; i < NR; i++)
            if (k < 0 && bus.req[(m_ptr + i) % NR]) k = (m_ptr + i) % NR;
        ea = '0;
        if (k >= 0) begin
            eg[k] = 1'b1;
            ea    = bus.addr[k*AW +: AW];
        end
        eo = (k >= 0) && (int'(ea) >= DEPTH);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
        chk({tag, ".rom_address"}, 32'(bus.rom_address), 32'(ea));
        r.v = eg;
        r.d = (k >= 0 && !eo) ? rom_fn(ea) : '0;
        r.o = eo;
        sb.push_back(r);
        last_idx = k;
        if (k >= 0) m_ptr = (k + 1) % NR;
        @(posedge vga_clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            r = sb.pop_front();
            got.v = bus.rd_valid;
            got.d = bus.rd_data;
            got.o = bus.rd_oob;
            chk({tag, ".rd_valid"}, 32'(got.v), 32'(r.v));
            chk({tag, ".rd_data"}, 32'(got.d), 32'(r.d));
            chk({tag, ".rd_oob"}, 32'(got.o), 32'(r.o));
        end
    endtask

    task automatic do_reset();
        @(posedge vga_clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        m_ptr = 0;
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.addr = '0;
        for (int i = 0; i < NR; i++) set_addr(i, 10 + i);

        // Reset state, with requests pending so gnt masking is exercised.
        bus.req = 4'b1111;
        #3;
        chk("rst.gnt", 32'(bus.gnt), 32'd0);
        chk("rst.rom_address", 32'(bus.rom_address), 32'd0);
        chk("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst.rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst.rd_oob", 32'(bus.rd_oob), 32'd0);
        bus.req = '0;
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;

        // Single request
        bus.req = 4'b0001;
        set_addr(0, 15);
        tick("single");
        chk("single.rom15", 32'(rom_fn(8'd15)), 32'd3);

        // All four continuously from reset
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick("all4");
            chk("all4.order", 32'(last_idx), 32'(i % 4));
        end

        // Requesters 0 and 2 alternate
        do_reset();
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick("alt02");
            chk("alt02.order", 32'(last_idx), 32'((i % 2) * 2));
        end

        // Out-of-range reads and the depth boundary
        bus.req = 4'b0010;
        set_addr(1, 200); tick("oob200");
        set_addr(1, 20);  tick("inr20");
        set_addr(1, 196); tick("oob196");
        set_addr(1, 195); tick("inr195");
        set_addr(1, 255); tick("oob255");

        // Reset mid-operation while a grant to requester 3 is in flight
        bus.req = 4'b1000;
        set_addr(3, 42);
        tick("pre_rst");
        @(negedge vga_clk);
        #1;
        chk("midrst.gnt_before", 32'(bus.gnt), 32'b1000);
        reset_n = 1'b0;
        #1;
        chk("midrst.gnt", 32'(bus.gnt), 32'd0);
        chk("midrst.rom_address", 32'(bus.rom_address), 32'd0);
        chk("midrst.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("midrst.rd_data", 32'(bus.rd_data), 32'd0);
        @(posedge vga_clk);
        #1;
        chk("midrst.no_return", 32'(bus.rd_valid), 32'd0);
        sb.delete();
        m_ptr = 0;
        reset_n = 1'b1;
        tick("post_rst");
        chk("post_rst.idx", 32'(last_idx), 32'd3);

        // Idle holds ptr; requester 1 is granted immediately afterwards
        bus.req = 4'b0010;
        set_addr(1, 7);
        tick("set_ptr2");
        bus.req = '0;
        for (int i = 0; i < 10; i++) tick("idle");
        bus.req = 4'b1111;
        tick("after_idle");
        chk("after_idle.idx", 32'(last_idx), 32'd2);
        bus.req = 4'b0010;
        tick("req1");
        chk("req1.idx", 32'(last_idx), 32'd1);

        // Random traffic against the scoreboard
        for (int n = 0; n < 40; n++) begin
            bus.req = NR'($urandom_range(0, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) set_addr(i, int'($urandom_range(0, 255)));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM, with its 2-bit palette-index output, between several per-object sprite renderers (player ship, enemies, projectiles) in the pixel pipeline. Each cycle, a round-robin policy grants at most one requester and drives that requester's address to the ROM. One cycle later it returns the palette index to that requester. It sits between the renderers and the `*_rom` instance, all on `vga_clk`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 8, ROM address width
- `DATA_W`, 2, palette index width
- `ROM_DEPTH`, 196, valid entries (14x14 sprite)

Ports:
- `vga_clk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester read request, level
- `addr`  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- `gnt`  out  NUM_REQ  one-hot grant, combinational, same cycle as `req`
- `rom_address`  out  ADDR_W  address to the ROM, combinational from the granted requester
- `rom_q`  in  DATA_W  ROM data, valid before the next `vga_clk` rising edge (ROM clocked on `~vga_clk`)
- `rd_valid`  out  NUM_REQ  one-hot data-return strobe, registered
- `rd_data`  out  DATA_W  returned palette index, registered
- `rd_oob`  out  1  returned read was out of range, registered

## Operation
- Request handshake:
  - A requester holds `req` high and `addr` stable until it sees `gnt[i]` high at a rising edge.
  - The transfer completes on that edge.
  - The requester may drop `req` or present a new address in the next cycle.
- Grant selection:
  - Scan starts at pointer `ptr` and proceeds `ptr, ptr+1, … NUM_REQ-1, 0, …` (mod NUM_REQ).
  - The first asserted `req` wins.
  - Exactly one `gnt` bit is high whenever any `req` is high; `gnt` is all-zero otherwise.
- Pointer update:
  - After a grant to index k, `ptr` becomes (k+1) mod NUM_REQ.
  - With no grant, `ptr` holds.
- `rom_address`:
  - Equals the granted `addr` when a grant is made.
  - Is 0 otherwise.
- Out-of-range reads:
  - A granted `addr` ≥ ROM_DEPTH is still granted.
  - Its return has `rd_data` forced to 0 (transparent index) and `rd_oob`=1.
- Return stage registers, at the edge ending the grant cycle:
  - `rd_valid` ← `gnt`
  - `rd_data` ← (oob ? 0 : `rom_q`)
  - `rd_oob` ← grant & oob
- With no grant, `rd_valid`=0, and `rd_data` and `rd_oob` are cleared to 0.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.

## Timing
- Reset values (async, while `reset_n`=0):
  - `ptr`=0, `rd_valid`=0, `rd_data`=0, `rd_oob`=0
  - `gnt` forced to 0 and `rom_address` forced to 0 while reset is asserted
- Latency:
  - Grant is in cycle t, the same cycle as `req`.
  - `rd_valid[i]`/`rd_data` are valid for exactly one cycle, t+1.
- Throughput: one read per cycle, back-to-back. The same requester may be granted in consecutive cycles only if no other `req` is high.
- Simultaneous events:
  - The return for grant t and the grant for t+1 occur in the same cycle independently.
  - A requester can receive `rd_valid` and `gnt` together.
- Reset mid-operation:
  - An in-flight return is discarded, and `rd_valid` is never asserted for it.
  - After release, arbitration starts at `ptr`=0.
  - Requesters re-issue any read whose data they did not receive.
- Reset release: on the first rising edge with `reset_n`=1, grants resume normally. There is no warm-up cycle.

## Structure
- Shared package `sprite_pkg` holds:
  - `SPRITE_DIM`=14 and `SPRITE_ROM_DEPTH`=196
  - `PAL_IDX_W`=2 and the transparent index constant `PAL_TRANSPARENT`=0
  - typedef `pal_idx_t`
- Sub-module `sprite_rr_pick`:
  - Purely combinational.
  - Maps `req` and `ptr` to one-hot `gnt` and encoded index.
- The top module owns `ptr`, the address mux, the out-of-range compare and the return registers.

## Test plan
- Single request: req=0001 with addr0=15 → `gnt`=0001 and `rom_address`=15 in the same cycle; the next cycle gives `rd_valid`=0001 and `rd_data`=ROM[15].
- All four request continuously from reset → grant order 0,1,2,3,0,1; each requester receives one `rd_valid` per 4 cycles.
- Requesters 0 and 2 always request and `ptr` starts at 0 → grants alternate 0,2,0,2; `rd_valid` alternates 0001/0100 one cycle behind.
- addr1=200 with only req1 → `gnt`=0010; next cycle `rd_valid`=0010, `rd_data`=0, `rd_oob`=1. A following in-range read clears `rd_oob` to 0.
- Assert `reset_n`=0 mid-cycle right after a grant to requester 3 → outputs clear immediately and no `rd_valid` appears. After release with req=1000, requester 3 is granted on the first cycle.
- Idle: req=0000 for 10 cycles → `gnt`=0, `rom_address`=0, `rd_valid`=0, `ptr` unchanged. The next request from requester 1 is granted immediately.
